// File: rtl/ili9341_fill.sv
// Memory-mapped rectangle fill engine for an ILI9341 panel on an 8-bit 8080-style bus.
// Emits CASET/PASET/RAMWR followed by N RGB565 pixels, one byte per SETUP/STROBE/HOLD.
module ili9341_fill #(
  parameter int STROBE_LEN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        cmd_data,
  output logic        write_edge,
  output logic [7:0]  dout,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR, S_PIXELS, S_DONE} seq_state_t;
  typedef enum logic [1:0] {P_IDLE, P_SETUP, P_STROBE, P_HOLD} phase_t;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_LEN - 1);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return r;
  endfunction

  // {cmd_data, dout} for byte idx of a sequencer state
  function automatic logic [8:0] sel_byte(input seq_state_t st, input logic [2:0] idx,
                                          input logic [31:0] xw, input logic [31:0] yw,
                                          input logic [15:0] col);
    logic [31:0] w;
    logic [8:0]  b;
    w = (st == S_CASET) ? xw : yw;
    b = {1'b0, 8'h00};
    case (st)
      S_CASET, S_PASET: begin
        case (idx)
          3'd0:    b = {1'b0, ((st == S_CASET) ? 8'h2A : 8'h2B)};
          3'd1:    b = {1'b1, w[15:8]};
          3'd2:    b = {1'b1, w[7:0]};
          3'd3:    b = {1'b1, w[31:24]};
          3'd4:    b = {1'b1, w[23:16]};
          default: b = {1'b0, 8'h00};
        endcase
      end
      S_RAMWR:  b = {1'b0, 8'h2C};
      S_PIXELS: b = (idx == 3'd0) ? {1'b1, col[15:8]} : {1'b1, col[7:0]};
      default:  b = {1'b0, 8'h00};
    endcase
    return b;
  endfunction

  logic        ready_r, busy_r, err_r, abort_r, cmd_data_r, write_edge_r;
  logic [31:0] rdata_r, xwin_r, ywin_r, pix_cnt_r;
  logic [15:0] color_r;
  logic [7:0]  dout_r;
  logic [3:0]  scnt_r;
  logic [2:0]  idx_r, next_idx_s;
  seq_state_t  state_r, next_state_s;
  phase_t      phase_r;

  logic        req_s, wr_s, rd_s, ctrl_wr_s, start_req_s, start_s, abort_wr_s, abort_s;
  logic        win_bad_s, byte_end_s, next_is_byte_s;
  logic [7:0]  reg_sel_s;
  logic [31:0] xwin_merge_s, ywin_merge_s, color_merge_s, width_s, height_s, npix_s;
  logic [8:0]  next_byte_s;
  logic        unused_s;

  assign req_s          = iomem_valid & ~ready_r;
  assign wr_s           = req_s & (|iomem_wstrb);
  assign rd_s           = req_s & ~(|iomem_wstrb);
  assign reg_sel_s      = iomem_addr[7:0];
  assign ctrl_wr_s      = wr_s & (reg_sel_s == 8'h0C) & iomem_wstrb[0];
  assign abort_wr_s     = ctrl_wr_s & iomem_wdata[1] & busy_r;
  assign start_req_s    = ctrl_wr_s & iomem_wdata[0] & ~iomem_wdata[1] & ~busy_r;
  assign win_bad_s      = (xwin_r[31:16] < xwin_r[15:0]) | (ywin_r[31:16] < ywin_r[15:0]);
  assign start_s        = start_req_s & ~win_bad_s;
  assign abort_s        = abort_r | abort_wr_s;
  assign byte_end_s     = (phase_r == P_HOLD);
  assign xwin_merge_s   = merge_bytes(xwin_r, iomem_wdata, iomem_wstrb);
  assign ywin_merge_s   = merge_bytes(ywin_r, iomem_wdata, iomem_wstrb);
  assign color_merge_s  = merge_bytes({16'h0000, color_r}, iomem_wdata, iomem_wstrb);
  assign width_s        = {16'h0000, xwin_r[31:16]} - {16'h0000, xwin_r[15:0]} + 32'd1;
  assign height_s       = {16'h0000, ywin_r[31:16]} - {16'h0000, ywin_r[15:0]} + 32'd1;
  assign npix_s         = width_s * height_s;
  assign next_byte_s    = sel_byte(next_state_s, next_idx_s, xwin_r, ywin_r, color_r);
  assign next_is_byte_s = (next_state_s != S_IDLE) & (next_state_s != S_DONE);
  assign unused_s       = ^iomem_addr[31:8];

  assign iomem_ready = ready_r;
  assign iomem_rdata = rdata_r;
  assign cmd_data    = cmd_data_r;
  assign write_edge  = write_edge_r;
  assign dout        = dout_r;
  assign busy        = busy_r;

  // Bus acknowledge, read mux and configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r <= 1'b0;
      rdata_r <= 32'd0;
      xwin_r  <= 32'd0;
      ywin_r  <= 32'd0;
      color_r <= 16'd0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= req_s;
      if (rd_s) begin
        case (reg_sel_s)
          8'h00:   rdata_r <= xwin_r;
          8'h04:   rdata_r <= ywin_r;
          8'h08:   rdata_r <= {16'h0000, color_r};
          8'h10:   rdata_r <= {30'd0, err_r, busy_r};
          default: rdata_r <= 32'd0;
        endcase
      end else begin
        rdata_r <= 32'd0;
      end
      if (wr_s && !busy_r) begin
        case (reg_sel_s)
          8'h00:   xwin_r  <= xwin_merge_s;
          8'h04:   ywin_r  <= ywin_merge_s;
          8'h08:   color_r <= color_merge_s[15:0];
          default: begin end
        endcase
      end
      if (start_req_s) begin
        err_r <= win_bad_s;
      end
    end
  end

  // Sequencer next state: advances only at the end of a byte's HOLD phase
  always_comb begin
    next_state_s = state_r;
    next_idx_s   = idx_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        next_idx_s = 3'd0;
        if (start_s) begin
          next_state_s = S_CASET;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      default: begin
        if (!byte_end_s) begin
          next_state_s = state_r;
        end else if (abort_s) begin
          next_state_s = S_DONE;
        end else begin
          case (state_r)
            S_CASET, S_PASET: begin
              if (idx_r == 3'd4) begin
                next_state_s = (state_r == S_CASET) ? S_PASET : S_RAMWR;
                next_idx_s   = 3'd0;
              end else begin
                next_idx_s = idx_r + 3'd1;
              end
            end
            S_RAMWR: begin
              next_state_s = S_PIXELS;
              next_idx_s   = 3'd0;
            end
            S_PIXELS: begin
              if (idx_r == 3'd0) begin
                next_idx_s = 3'd1;
              end else if (pix_cnt_r == 32'd1) begin
                next_state_s = S_DONE;
              end else begin
                next_idx_s = 3'd0;
              end
            end
            default: next_state_s = S_DONE;
          endcase
        end
      end
    endcase
  end

  // Sequencer registers and the SETUP/STROBE/HOLD byte engine
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      idx_r        <= 3'd0;
      pix_cnt_r    <= 32'd0;
      phase_r      <= P_IDLE;
      scnt_r       <= 4'd0;
      dout_r       <= 8'd0;
      cmd_data_r   <= 1'b0;
      write_edge_r <= 1'b0;
      busy_r       <= 1'b0;
      abort_r      <= 1'b0;
    end else begin
      state_r <= next_state_s;
      idx_r   <= next_idx_s;
      if (start_s) begin
        pix_cnt_r <= npix_s;
      end else if (byte_end_s && (state_r == S_PIXELS) && (idx_r == 3'd1)) begin
        pix_cnt_r <= pix_cnt_r - 32'd1;
      end
      if (start_s) begin
        busy_r <= 1'b1;
      end else if (next_state_s == S_DONE) begin
        busy_r <= 1'b0;
      end
      if (abort_wr_s) begin
        abort_r <= 1'b1;
      end else if ((state_r == S_IDLE) || (state_r == S_DONE)) begin
        abort_r <= 1'b0;
      end
      case (phase_r)
        P_IDLE: begin
          if (start_s) begin
            {cmd_data_r, dout_r} <= next_byte_s;
            phase_r              <= P_SETUP;
          end
        end
        P_SETUP: begin
          write_edge_r <= 1'b1;
          scnt_r       <= 4'd0;
          phase_r      <= P_STROBE;
        end
        P_STROBE: begin
          if (scnt_r == STROBE_LAST) begin
            write_edge_r <= 1'b0;
            phase_r      <= P_HOLD;
          end else begin
            scnt_r <= scnt_r + 4'd1;
          end
        end
        P_HOLD: begin
          if (next_is_byte_s) begin
            {cmd_data_r, dout_r} <= next_byte_s;
            phase_r              <= P_SETUP;
          end else begin
            phase_r <= P_IDLE;
          end
        end
        default: phase_r <= P_IDLE;
      endcase
    end
  end

endmodule
